seq_detect_controller: RTL and testbench



---
 rtl/seq_ctrl_pkg.sv | 16 +
 rtl/seq_ctrl_delay.sv | 23 ++
 rtl/seq_detect_controller.sv | 111 +++++++++++
 tb/tb_seq_detect_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - state encoding and width helper shared by the sequence detector controller and its bench
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_REPORT = 2'b11
  } state_t;

  // Wide enough to hold 0..w detections.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_ctrl_delay.sv
// rtl/seq_ctrl_delay.sv - DEPTH-stage delay line aligning the sample enable with the detector response
module seq_ctrl_delay #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | DEPTH'(d);
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/seq_detect_controller.sv
// rtl/seq_detect_controller.sv - word-to-serial sequencer that scores detector pulses per word
module seq_detect_controller
  import seq_ctrl_pkg::*;
#(
  parameter int W           = 8,
  parameter int DET_LATENCY = 1,
  parameter int CNT_W       = cnt_width(W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             seq_out,
  input  logic             detect_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [1:0]       state
);

  localparam int                 IDX_W      = $clog2(W);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(W - 1);
  localparam logic [2:0]         DRAIN_LAST = 3'((DET_LATENCY > 0) ? DET_LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(W);

  state_t           cur_state;
  state_t           next_state;
  logic [W-1:0]     sreg;
  logic [IDX_W-1:0] bit_idx;
  logic [2:0]       drain_cnt;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             shifting;
  logic             sample;

  assign accept   = (cur_state == ST_IDLE) && in_valid;
  assign shifting = (cur_state == ST_SHIFT);

  // Detector responses to bit i arrive DET_LATENCY clocks after bit i is driven.
  generate
    if (DET_LATENCY > 0) begin : g_delay
      seq_ctrl_delay #(.DEPTH(DET_LATENCY)) u_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (shifting),
        .q       (sample)
      );
    end else begin : g_bypass
      assign sample = shifting;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    seq_out    = 1'b1;
    case (cur_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        seq_out = sreg[W-1];
        if (bit_idx == LAST_IDX) next_state = (DET_LATENCY > 0) ? ST_DRAIN : ST_REPORT;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) next_state = ST_REPORT;
      end
      ST_REPORT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg      <= '0;
      bit_idx   <= '0;
      drain_cnt <= '0;
      count     <= '0;
    end else if (accept) begin
      sreg      <= in_data;
      bit_idx   <= '0;
      drain_cnt <= '0;
      count     <= '0;
    end else begin
      if (shifting) begin
        sreg    <= {sreg[W-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end
      if (cur_state == ST_DRAIN) drain_cnt <= drain_cnt + 3'd1;
      if (sample && detect_in && (count != CNT_MAX)) count <= count + 1'b1;
    end
  end

  assign out_count = count;
  assign state     = cur_state;

endmodule

// File: tb/tb_seq_detect_controller.sv
// tb/tb_seq_detect_controller.sv - self-checking bench for seq_detect_controller with reference 00 detectors
module tb_seq_detect_controller;
  import seq_ctrl_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       force_en;
  logic       sel;

  logic       in_ready1, seq_out1, out_valid1, det_in1;
  logic [3:0] out_count1;
  logic [1:0] state1;
  logic       in_ready0, seq_out0, out_valid0, det_in0;
  logic [3:0] out_count0;
  logic [1:0] state0;

  logic       in_valid1, in_valid0;
  logic       prev1, det_q1, prev0;

  logic       ob_ready, ob_seq, ob_valid;
  logic [3:0] ob_count;
  logic [1:0] ob_state;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic drain_seen1 = 1'b0;
  logic drain_seen0 = 1'b0;

  assign in_valid1 = in_valid & ~sel;
  assign in_valid0 = in_valid & sel;

  seq_detect_controller #(.W(8), .DET_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .seq_out(seq_out1), .detect_in(det_in1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_count(out_count1), .state(state1)
  );

  seq_detect_controller #(.W(8), .DET_LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data), .seq_out(seq_out0), .detect_in(det_in0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_count(out_count0), .state(state0)
  );

  // Registered reference detector: one clock latency.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev1  <= 1'b1;
      det_q1 <= 1'b0;
    end else begin
      prev1  <= seq_out1;
      det_q1 <= !prev1 && !seq_out1;
    end
  end
  assign det_in1 = det_q1 | (force_en && (state1 == 2'b00 || state1 == 2'b11));

  // Combinational reference detector: zero latency.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev0 <= 1'b1;
    else          prev0 <= seq_out0;
  end
  assign det_in0 = !prev0 && !seq_out0;

  assign ob_ready = sel ? in_ready0  : in_ready1;
  assign ob_seq   = sel ? seq_out0   : seq_out1;
  assign ob_valid = sel ? out_valid0 : out_valid1;
  assign ob_count = sel ? out_count0 : out_count1;
  assign ob_state = sel ? state0     : state1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc_cnt <= cyc_cnt + 1;
    if (state1 == 2'b10) drain_seen1 <= 1'b1;
    if (state0 == 2'b10) drain_seen0 <= 1'b1;
  end

  // Count of 00 pairs in the MSB-first bit stream, the line idling at 1 before bit 0.
  function automatic int model_count(input logic [7:0] w);
    int n;
    logic prev;
    n = 0;
    prev = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (!prev && !w[i]) n++;
      prev = w[i];
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // hold < 0: out_ready held high; hold >= 1: out_ready low for hold REPORT cycles.
  task automatic run_word(input logic [7:0] word, input int hold, input int exp_lat, output int acc);
    int waited;
    int lat;
    logic [7:0] bits;
    out_ready = (hold < 0);
    waited = 0;
    while (!ob_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    chk("in_ready_wait", 32'(ob_ready), 1);
    in_data  = word;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    acc  = cyc_cnt;
    bits = '0;
    lat  = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= 8) bits = {bits[6:0], ob_seq};
      if (ob_valid) begin
        lat = c;
        break;
      end
      @(negedge clock);
    end
    chk("serial_bits", 32'(bits), 32'(word));
    chk("latency", lat, exp_lat);
    chk("count", 32'(ob_count), model_count(word));
    if (hold < 0) begin
      @(negedge clock);
      chk("idle_after_report", 32'(ob_state), 32'(ST_IDLE));
    end else begin
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", 32'(ob_valid), 1);
        chk("hold_count", 32'(ob_count), model_count(word));
        chk("hold_in_ready", 32'(ob_ready), 0);
        if (h < hold - 1) @(negedge clock);
      end
      out_ready = 1'b1;
      @(negedge clock);
      chk("idle_after_accept", 32'(ob_state), 32'(ST_IDLE));
      chk("valid_after_accept", 32'(ob_valid), 0);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int acc_a, acc_b;
    int hold;
    logic seen;
    logic [7:0] w;

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; force_en = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready1", 32'(in_ready1), 1);
    chk("rst_seq_out1", 32'(seq_out1), 1);
    chk("rst_out_valid1", 32'(out_valid1), 0);
    chk("rst_out_count1", 32'(out_count1), 0);
    chk("rst_state1", 32'(state1), 32'(ST_IDLE));
    chk("rst_in_ready0", 32'(in_ready0), 1);
    chk("rst_out_valid0", 32'(out_valid0), 0);
    chk("rst_state0", 32'(state0), 32'(ST_IDLE));
    reset_n = 1'b1;
    @(negedge clock);

    // Word of zeros: seven 00 pairs, result 10 cycles after accept.
    run_word(8'h00, 1, 10, acc_a);

    // Back-to-back words at the minimum period with out_ready tied high.
    run_word(8'hFF, -1, 10, acc_a);
    run_word(8'hAA, -1, 10, acc_b);
    chk("period_ff_aa", acc_b - acc_a, 11);
    run_word(8'hCC, -1, 10, acc_a);
    chk("period_aa_cc", acc_a - acc_b, 11);

    // Result held for five cycles under back-pressure.
    run_word(8'h00, 5, 10, acc_a);

    // Detector forced high only in IDLE and REPORT must not be counted.
    force_en = 1'b1;
    repeat (3) @(negedge clock);
    run_word(8'hFF, 3, 10, acc_a);
    repeat (2) @(negedge clock);
    force_en = 1'b0;

    // Reset asserted while bit 3 is on the line discards the word.
    in_data = 8'h00; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_shift_state", 32'(state1), 32'(ST_SHIFT));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid1), 0);
    chk("mid_rst_seq_out", 32'(seq_out1), 1);
    chk("mid_rst_state", 32'(state1), 32'(ST_IDLE));
    chk("mid_rst_count", 32'(out_count1), 0);
    chk("mid_rst_in_ready", 32'(in_ready1), 1);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (out_valid1) seen = 1'b1;
    end
    chk("no_report_after_reset", 32'(seen), 0);
    run_word(8'hCC, 1, 10, acc_a);

    // Random words against the pair-count model.
    for (int k = 0; k < 10; k++) begin
      w = 8'($urandom);
      hold = int'($urandom_range(0, 3));
      if (hold == 0) hold = -1;
      run_word(w, hold, 10, acc_a);
    end

    // Zero-latency configuration.
    out_ready = 1'b0;
    sel = 1'b1;
    @(negedge clock);
    run_word(8'h00, 1, 9, acc_a);
    run_word(8'hCC, -1, 9, acc_a);
    for (int k = 0; k < 5; k++) begin
      w = 8'($urandom);
      hold = int'($urandom_range(0, 2));
      if (hold == 0) hold = -1;
      run_word(w, hold, 9, acc_a);
    end
    chk("drain_never_l0", 32'(drain_seen0), 0);
    chk("drain_seen_l1", 32'(drain_seen1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
